recovery_receiver: RTL and testbench

Parses inbound recovery-protocol writes from the target-side TTI RX queues into a command record plus a payload byte stream for the recovery register logic. It is the receive-direction counterpart of the recovery transmitter. It sits between the TTI RX descriptor/data queues and the recovery command executor, and drives the shared PEC calculator. Frame layout: CMD, LEN_L, LEN_H, LEN payload bytes, PEC. A read request is a frame carrying only CMD.

---
 rtl/recovery_receiver.sv | 245 ++++++++++++++++++++++++
 tb/tb_recovery_receiver.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/recovery_receiver.sv
// Recovery-protocol receive parser: TTI RX descriptor/data queues -> command record + payload stream.
// Optional PEC verification is compiled in with `define RECOVERY_PEC_CHECK_EN.
module recovery_receiver #(
   parameter int TtiRxDescDataWidth = 32
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          soft_reset_ni,
   input  logic                          desc_valid_i,
   output logic                          desc_ready_o,
   input  logic [TtiRxDescDataWidth-1:0] desc_data_i,
   input  logic                          data_valid_i,
   output logic                          data_ready_o,
   input  logic [7:0]                    data_data_i,
   input  logic [7:0]                    pec_crc_i,
   output logic                          pec_enable_o,
   output logic                          pec_clear_o,
   output logic                          cmd_valid_o,
   input  logic                          cmd_ready_i,
   output logic [7:0]                    cmd_cmd_o,
   output logic [15:0]                   cmd_len_o,
   output logic                          cmd_is_read_o,
   output logic                          cmd_error_o,
   output logic                          cmd_dvalid_o,
   input  logic                          cmd_dready_i,
   output logic [7:0]                    cmd_data_o,
   output logic                          cmd_dlast_o
);

   typedef enum logic [2:0] {
      Idle,
      RxCmd,
      RxLenL,
      RxLenH,
      RxData,
      RxPEC,
      Flush,
      Done
   } state_e;

   state_e      state_q, state_d;
   logic        rdy_q;
   logic [15:0] cnt_q, cnt_d;
   logic [15:0] rem_q, rem_d;
   logic [15:0] dcnt_q, dcnt_d;
   logic [15:0] len_q, len_d;
   logic [7:0]  cmd_q, cmd_d;
   logic        is_read_q, is_read_d;
   logic        error_q, error_d;

   logic        desc_fire;
   logic        data_fire;
   logic [15:0] new_len;

   if (TtiRxDescDataWidth > 16) begin : g_desc_hi
      logic unused_desc_hi;
      assign unused_desc_hi = ^desc_data_i[TtiRxDescDataWidth-1:16];
   end

`ifndef RECOVERY_PEC_CHECK_EN
   logic unused_pec_crc;
   assign unused_pec_crc = ^pec_crc_i;
`endif

   assign desc_fire = desc_valid_i & desc_ready_o;
   assign data_fire = data_valid_i & data_ready_o;
   assign new_len   = {data_data_i, len_q[7:0]};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= Idle;
         rdy_q     <= 1'b0;
         cnt_q     <= '0;
         rem_q     <= '0;
         dcnt_q    <= '0;
         len_q     <= '0;
         cmd_q     <= '0;
         is_read_q <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         rdy_q     <= 1'b1;
         cnt_q     <= cnt_d;
         rem_q     <= rem_d;
         dcnt_q    <= dcnt_d;
         len_q     <= len_d;
         cmd_q     <= cmd_d;
         is_read_q <= is_read_d;
         error_q   <= error_d;
      end
   end

   // rem_q tracks bytes of the frame not yet consumed so Flush knows when the frame ends.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      rem_d        = rem_q;
      dcnt_d       = dcnt_q;
      len_d        = len_q;
      cmd_d        = cmd_q;
      is_read_d    = is_read_q;
      error_d      = error_q;
      desc_ready_o = 1'b0;
      data_ready_o = 1'b0;
      pec_clear_o  = 1'b0;
      cmd_valid_o  = 1'b0;
      cmd_dvalid_o = 1'b0;
      cmd_data_o   = '0;
      cmd_dlast_o  = 1'b0;

      case (state_q)
         Idle: begin
            desc_ready_o = rdy_q;
            if (desc_fire) begin
               cnt_d       = desc_data_i[15:0];
               rem_d       = desc_data_i[15:0];
               cmd_d       = '0;
               len_d       = '0;
               is_read_d   = 1'b0;
               error_d     = 1'b0;
               pec_clear_o = 1'b1;
               if (desc_data_i[15:0] == 16'd0) begin
                  error_d = 1'b1;
                  state_d = Done;
               end else begin
                  state_d = RxCmd;
               end
            end
         end

         RxCmd: begin
            data_ready_o = 1'b1;
            if (data_fire) begin
               cmd_d = data_data_i;
               rem_d = rem_q - 16'd1;
               if (cnt_q == 16'd1) begin
                  is_read_d = 1'b1;
                  state_d   = Done;
               end else if (cnt_q == 16'd2 || cnt_q == 16'd3) begin
                  error_d = 1'b1;
                  state_d = Flush;
               end else begin
                  state_d = RxLenL;
               end
            end
         end

         RxLenL: begin
            data_ready_o = 1'b1;
            if (data_fire) begin
               len_d[7:0] = data_data_i;
               rem_d      = rem_q - 16'd1;
               state_d    = RxLenH;
            end
         end

         // The count must cover CMD + two length bytes + payload + PEC; compare in 17 bits.
         RxLenH: begin
            data_ready_o = 1'b1;
            if (data_fire) begin
               len_d[15:8] = data_data_i;
               rem_d       = rem_q - 16'd1;
               if ({1'b0, cnt_q} != ({1'b0, new_len} + 17'd4)) begin
                  error_d = 1'b1;
                  state_d = Flush;
               end else if (new_len == 16'd0) begin
                  state_d = RxPEC;
               end else begin
                  dcnt_d  = new_len;
                  state_d = RxData;
               end
            end
         end

         RxData: begin
            data_ready_o = cmd_dready_i;
            cmd_dvalid_o = data_valid_i;
            cmd_data_o   = data_data_i;
            cmd_dlast_o  = (dcnt_q == 16'd1);
            if (data_fire) begin
               dcnt_d = dcnt_q - 16'd1;
               rem_d  = rem_q - 16'd1;
               if (dcnt_q == 16'd1) begin
                  state_d = RxPEC;
               end
            end
         end

         RxPEC: begin
            data_ready_o = 1'b1;
            if (data_fire) begin
               rem_d = rem_q - 16'd1;
`ifdef RECOVERY_PEC_CHECK_EN
               if (data_data_i != pec_crc_i) begin
                  error_d = 1'b1;
               end
`endif
               state_d = Done;
            end
         end

         Flush: begin
            data_ready_o = 1'b1;
            if (data_fire) begin
               rem_d = rem_q - 16'd1;
               if (rem_q <= 16'd1) begin
                  state_d = Done;
               end
            end
         end

         Done: begin
            cmd_valid_o = 1'b1;
            if (cmd_ready_i) begin
               state_d = Idle;
            end
         end

         default: begin
            state_d = Idle;
         end
      endcase

      if (!soft_reset_ni) begin
         state_d = Idle;
      end
   end

`ifdef RECOVERY_PEC_CHECK_EN
   always_comb begin
      pec_enable_o = 1'b0;
      if (state_q == RxCmd || state_q == RxLenL || state_q == RxLenH || state_q == RxData) begin
         pec_enable_o = data_fire;
      end
   end
`else
   assign pec_enable_o = 1'b0;
`endif

   assign cmd_cmd_o     = cmd_q;
   assign cmd_len_o     = len_q;
   assign cmd_is_read_o = is_read_q;
   assign cmd_error_o   = error_q;

endmodule

// File: tb/tb_recovery_receiver.sv
// Self-checking bench for recovery_receiver: directed plus randomized frames against a frame-level model.
// Models the external CRC-8 (poly 0x07) PEC calculator; honours `define RECOVERY_PEC_CHECK_EN.
module tb_recovery_receiver;

`ifdef RECOVERY_PEC_CHECK_EN
   localparam bit PecOn = 1'b1;
`else
   localparam bit PecOn = 1'b0;
`endif

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        soft_reset_ni;
   logic        desc_valid_i;
   logic        desc_ready_o;
   logic [31:0] desc_data_i;
   logic        data_valid_i;
   logic        data_ready_o;
   logic [7:0]  data_data_i;
   logic [7:0]  pec_crc_i;
   logic        pec_enable_o;
   logic        pec_clear_o;
   logic        cmd_valid_o;
   logic        cmd_ready_i;
   logic [7:0]  cmd_cmd_o;
   logic [15:0] cmd_len_o;
   logic        cmd_is_read_o;
   logic        cmd_error_o;
   logic        cmd_dvalid_o;
   logic        cmd_dready_i;
   logic [7:0]  cmd_data_o;
   logic        cmd_dlast_o;

   int errors = 0;
   int checks = 0;

   logic [7:0]  frameQ[$];
   logic [7:0]  expPay[$];
   logic [7:0]  gotData[$];
   logic        gotLast[$];
   logic [7:0]  expCmd;
   logic [15:0] expLen;
   logic        expRead;
   logic        expErr;
   logic [7:0]  crcReg;

   recovery_receiver #(.TtiRxDescDataWidth(32)) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .soft_reset_ni (soft_reset_ni),
      .desc_valid_i  (desc_valid_i),
      .desc_ready_o  (desc_ready_o),
      .desc_data_i   (desc_data_i),
      .data_valid_i  (data_valid_i),
      .data_ready_o  (data_ready_o),
      .data_data_i   (data_data_i),
      .pec_crc_i     (pec_crc_i),
      .pec_enable_o  (pec_enable_o),
      .pec_clear_o   (pec_clear_o),
      .cmd_valid_o   (cmd_valid_o),
      .cmd_ready_i   (cmd_ready_i),
      .cmd_cmd_o     (cmd_cmd_o),
      .cmd_len_o     (cmd_len_o),
      .cmd_is_read_o (cmd_is_read_o),
      .cmd_error_o   (cmd_error_o),
      .cmd_dvalid_o  (cmd_dvalid_o),
      .cmd_dready_i  (cmd_dready_i),
      .cmd_data_o    (cmd_data_o),
      .cmd_dlast_o   (cmd_dlast_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
      logic [7:0] x;
      x = c ^ d;
      for (int i = 0; i < 8; i++) begin
         x = x[7] ? ((x << 1) ^ 8'h07) : (x << 1);
      end
      return x;
   endfunction

   // External PEC calculator: updates one cycle after enable, cleared by a one-cycle pulse.
   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         crcReg <= 8'h00;
      end else if (pec_clear_o) begin
         crcReg <= 8'h00;
      end else if (pec_enable_o) begin
         crcReg <= crc8(crcReg, data_data_i);
      end
   end
   assign pec_crc_i = crcReg;

   function automatic logic [7:0] crcOf(input int n);
      logic [7:0] c;
      c = 8'h00;
      for (int i = 0; i < n; i++) begin
         c = crc8(c, frameQ[i]);
      end
      return c;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Frame-level reference: derive the record and payload from the byte list and declared count.
   task automatic buildExpect(input int count);
      int l;
      expCmd = 8'h00;
      expLen = 16'h0000;
      expRead = 1'b0;
      expErr = 1'b0;
      expPay.delete();
      if (count == 0) begin
         expErr = 1'b1;
      end else begin
         expCmd = frameQ[0];
         if (count == 1) begin
            expRead = 1'b1;
         end else if (count < 4) begin
            expErr = 1'b1;
         end else begin
            expLen = {frameQ[2], frameQ[1]};
            l = int'(expLen);
            if (count != l + 4) begin
               expErr = 1'b1;
            end else begin
               for (int i = 0; i < l; i++) expPay.push_back(frameQ[3 + i]);
               if (PecOn && frameQ[3 + l] != crcOf(3 + l)) expErr = 1'b1;
            end
         end
      end
   endtask

   task automatic sendDesc(input int count);
      int waited;
      waited = 0;
      @(negedge clk_i);
      desc_valid_i = 1'b1;
      desc_data_i  = {16'($urandom), 16'(count)};
      #1;
      while (!desc_ready_o && waited < 20) begin
         @(negedge clk_i);
         #1;
         waited++;
      end
      checkOutput("desc_accept", {31'd0, desc_ready_o}, 32'd1);
      @(posedge clk_i);
   endtask

   task automatic sendByte(input logic [7:0] b, input bit toggle);
      int waited;
      waited = 0;
      @(negedge clk_i);
      desc_valid_i = 1'b0;
      data_valid_i = 1'b1;
      data_data_i  = b;
      if (toggle) cmd_dready_i = ~cmd_dready_i;
      #1;
      while (!data_ready_o && waited < 50) begin
         @(negedge clk_i);
         if (toggle) cmd_dready_i = ~cmd_dready_i;
         #1;
         waited++;
      end
      if (!data_ready_o) begin
         checkOutput("byte_accept_timeout", {31'd0, data_ready_o}, 32'd1);
      end else begin
         if (cmd_dvalid_o && cmd_dready_i) begin
            gotData.push_back(cmd_data_o);
            gotLast.push_back(cmd_dlast_o);
         end
`ifndef RECOVERY_PEC_CHECK_EN
         checkOutput("pec_enable_off", {31'd0, pec_enable_o}, 32'd0);
`endif
         @(posedge clk_i);
      end
   endtask

   task automatic applyStimulus(input int count, input bit toggle, input int hold);
      buildExpect(count);
      gotData.delete();
      gotLast.delete();
      sendDesc(count);
      foreach (frameQ[i]) sendByte(frameQ[i], toggle);
      @(negedge clk_i);
      desc_valid_i = 1'b0;
      data_valid_i = 1'b0;
      cmd_dready_i = 1'b1;
      #1;
      checkOutput("cmd_valid_latency", {31'd0, cmd_valid_o}, 32'd1);
      checkOutput("rec_cmd", {24'd0, cmd_cmd_o}, {24'd0, expCmd});
      checkOutput("rec_len", {16'd0, cmd_len_o}, {16'd0, expLen});
      checkOutput("rec_is_read", {31'd0, cmd_is_read_o}, {31'd0, expRead});
      checkOutput("rec_error", {31'd0, cmd_error_o}, {31'd0, expErr});
      checkOutput("payload_count", gotData.size(), expPay.size());
      for (int i = 0; i < gotData.size() && i < expPay.size(); i++) begin
         checkOutput("payload_data", {24'd0, gotData[i]}, {24'd0, expPay[i]});
         checkOutput("payload_dlast", {31'd0, gotLast[i]}, (i == expPay.size() - 1) ? 32'd1 : 32'd0);
      end
      for (int h = 0; h < hold; h++) begin
         @(negedge clk_i);
         #1;
         checkOutput("rec_hold", {5'd0, cmd_valid_o, cmd_error_o, cmd_is_read_o, cmd_len_o, cmd_cmd_o},
                     {5'd0, 1'b1, expErr, expRead, expLen, expCmd});
      end
      @(negedge clk_i);
      cmd_ready_i = 1'b1;
      @(posedge clk_i);
      #1;
      cmd_ready_i = 1'b0;
      @(negedge clk_i);
      #1;
      checkOutput("rec_release", {30'd0, cmd_valid_o, desc_ready_o}, 32'd1);
   endtask

   task automatic validWrite(input logic [7:0] pecXor);
      frameQ = '{8'h26, 8'h04, 8'h00, 8'hA0, 8'hA1, 8'hA2, 8'hA3};
      frameQ.push_back(crcOf(7) ^ pecXor);
   endtask

   initial begin
      int len;
      int count;
      rst_ni = 1'b0;
      soft_reset_ni = 1'b1;
      desc_valid_i = 1'b0;
      desc_data_i = '0;
      data_valid_i = 1'b0;
      data_data_i = '0;
      cmd_ready_i = 1'b0;
      cmd_dready_i = 1'b1;

      repeat (3) @(negedge clk_i);
      #1;
      checkOutput("reset_outputs",
                  {desc_ready_o, data_ready_o, pec_enable_o, pec_clear_o, cmd_valid_o, cmd_is_read_o,
                   cmd_error_o, cmd_dvalid_o, cmd_dlast_o, cmd_cmd_o, cmd_data_o, 7'd0}, 32'd0);
      checkOutput("reset_len", {16'd0, cmd_len_o}, 32'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
      #1;
      checkOutput("desc_ready_after_reset", {31'd0, desc_ready_o}, 32'd1);

      $display("[TB] read request");
      frameQ = '{8'h22};
      applyStimulus(1, 1'b0, 0);

      $display("[TB] valid write");
      validWrite(8'h00);
      applyStimulus(8, 1'b0, 2);

      $display("[TB] bad PEC");
      validWrite(8'hFF);
      applyStimulus(8, 1'b0, 0);

      $display("[TB] length mismatch");
      frameQ = '{8'h26, 8'h04, 8'h00, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};
      applyStimulus(9, 1'b0, 1);

      $display("[TB] backpressure");
      validWrite(8'h00);
      applyStimulus(8, 1'b1, 5);

      $display("[TB] short counts");
      frameQ.delete();
      applyStimulus(0, 1'b0, 0);
      frameQ = '{8'h31, 8'h55};
      applyStimulus(2, 1'b0, 0);
      frameQ = '{8'h32, 8'h55, 8'h66};
      applyStimulus(3, 1'b0, 0);

      $display("[TB] soft reset mid payload");
      validWrite(8'h00);
      gotData.delete();
      gotLast.delete();
      sendDesc(8);
      for (int i = 0; i < 5; i++) sendByte(frameQ[i], 1'b0);
      @(negedge clk_i);
      data_valid_i = 1'b0;
      soft_reset_ni = 1'b0;
      @(posedge clk_i);
      #1;
      soft_reset_ni = 1'b1;
      @(negedge clk_i);
      #1;
      checkOutput("soft_reset_idle", {29'd0, desc_ready_o, data_ready_o, cmd_valid_o}, 32'd4);
      checkOutput("soft_reset_beats", gotData.size(), 32'd2);
      checkOutput("soft_reset_no_dlast", {31'd0, gotLast[1]}, 32'd0);
      validWrite(8'h00);
      applyStimulus(8, 1'b0, 0);

      $display("[TB] async reset mid frame");
      validWrite(8'h00);
      sendDesc(8);
      for (int i = 0; i < 3; i++) sendByte(frameQ[i], 1'b0);
      @(negedge clk_i);
      data_valid_i = 1'b0;
      rst_ni = 1'b0;
      #1;
      checkOutput("async_reset_outputs",
                  {24'd0, desc_ready_o, data_ready_o, cmd_valid_o, cmd_dvalid_o, cmd_error_o, cmd_is_read_o,
                   pec_clear_o, pec_enable_o}, 32'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
      #1;
      checkOutput("async_reset_ready", {31'd0, desc_ready_o}, 32'd1);
      frameQ = '{8'h5A, 8'h00, 8'h00};
      frameQ.push_back(crcOf(3));
      applyStimulus(4, 1'b0, 0);

      $display("[TB] random frames");
      for (int r = 0; r < 10; r++) begin
         len = $urandom_range(0, 6);
         frameQ = '{8'($urandom), 8'(len), 8'h00};
         for (int i = 0; i < len; i++) frameQ.push_back(8'($urandom));
         frameQ.push_back(crcOf(3 + len) ^ (($urandom_range(0, 2) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00));
         count = len + 4;
         if ($urandom_range(0, 3) == 0) begin
            int extra;
            extra = $urandom_range(1, 3);
            for (int i = 0; i < extra; i++) frameQ.push_back(8'($urandom));
            count += extra;
         end
         applyStimulus(count, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL global_timeout observed=running expected=finished");
      $fatal(1, "[TB] timeout");
   end

endmodule
